// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 opcodes,
// FSM state encoding and operand signedness helpers.
package muldiv_unit_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // state  | meaning
    // IDLE   | waiting for start, busy=0
    // CALC   | one multiply/divide bit per clock
    // FIX    | sign correction and word select into result
    // DONE   | one-cycle write-back strobe
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM (MULHSU treats it as unsigned).
    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_neg.sv
// Conditional two's-complement negate, width-parameterised, purely combinational.
module muldiv_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] negated
);

    // Pass through or negate depending on neg.
    always_comb begin
        negated = neg ? ((~value) + W'(1)) : value;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are converted to magnitudes
// at accept, iterated one bit per clock, then sign-corrected in FIX.
// Optional feature macro: MULDIV_EARLY_OUT_EN (early exit from CALC when the
// remaining multiplier bits are zero, or on a zero divisor).
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] rd_out
);

    localparam int              CNT_W     = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   calc_exit;

    logic [2:0]        op;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [CNT_W-1:0]  cnt;

    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mplier;
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   quot;

    logic              load_neg_a;
    logic              load_neg_b;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;

    logic              is_mul;
    logic              div_zero;
    logic              early_exit;
    logic [XLEN-1:0]   mplier_rest;
    logic [2*XLEN-1:0] product_step;
    logic [XLEN+1:0]   rem_shift;
    logic [XLEN+1:0]   rem_diff;
    logic              rem_fits;

    logic              signs_differ;
    logic [XLEN-1:0]   rem_src;
    logic [2*XLEN-1:0] product_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_next;

    // Operand magnitudes at load time.
    always_comb begin
        load_neg_a = rs1_data[XLEN-1] & rs1_is_signed(funct3);
        load_neg_b = rs2_data[XLEN-1] & rs2_is_signed(funct3);
    end

    muldiv_neg #(.W(XLEN)) u_neg_rs1 (.value(rs1_data), .neg(load_neg_a), .negated(rs1_mag));
    muldiv_neg #(.W(XLEN)) u_neg_rs2 (.value(rs2_data), .neg(load_neg_b), .negated(rs2_mag));

    // One iteration step: shift-add multiply and restoring divide.
    always_comb begin
        is_mul       = ~op[2];
        div_zero     = (b_mag == '0);
        mplier_rest  = mplier >> 1;
        product_step = mplier[0] ? (product + mcand) : product;
        rem_shift    = {rem, quot[XLEN-1]};
        rem_diff     = rem_shift - {2'b00, b_mag};
        rem_fits     = ~rem_diff[XLEN+1];
`ifdef MULDIV_EARLY_OUT_EN
        early_exit   = is_mul ? (mplier_rest == '0) : div_zero;
`else
        early_exit   = 1'b0;
`endif
        calc_exit    = (cnt == LAST_ITER) || early_exit;
    end

    // Sign correction and word select for the FIX cycle. A zero divisor
    // reproduces rs1 as remainder by re-applying the dividend sign to a_mag.
    always_comb begin
        signs_differ = sign_a ^ sign_b;
        rem_src      = div_zero ? a_mag : rem[XLEN-1:0];
    end

    muldiv_neg #(.W(2*XLEN)) u_neg_prod (.value(product), .neg(signs_differ), .negated(product_fix));
    muldiv_neg #(.W(XLEN))   u_neg_quot (.value(quot),    .neg(signs_differ), .negated(quot_fix));
    muldiv_neg #(.W(XLEN))   u_neg_rem  (.value(rem_src), .neg(sign_a),       .negated(rem_fix));

    // Select the architectural result for the latched opcode.
    always_comb begin
        result_next = rem_fix;
        case (op)
            F3_MUL:                       result_next = product_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_next = product_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_next = div_zero ? '1 : quot_fix;
            default:                      result_next = rem_fix;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and status outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (calc_exit) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture at accept, iterate in CALC, register result in FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            a_mag   <= '0;
            b_mag   <= '0;
            cnt     <= '0;
            mcand   <= '0;
            product <= '0;
            mplier  <= '0;
            rem     <= '0;
            quot    <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else if (accept) begin
            op      <= funct3;
            rd_out  <= rd_addr;
            sign_a  <= load_neg_a;
            sign_b  <= load_neg_b;
            a_mag   <= rs1_mag;
            b_mag   <= rs2_mag;
            cnt     <= '0;
            mcand   <= {{XLEN{1'b0}}, rs1_mag};
            product <= '0;
            mplier  <= rs2_mag;
            rem     <= '0;
            quot    <= rs1_mag;
        end else if (state == ST_CALC) begin
            cnt <= cnt + CNT_W'(1);
            if (is_mul) begin
                product <= product_step;
                mcand   <= mcand << 1;
                mplier  <= mplier_rest;
            end else begin
                rem  <= rem_fits ? rem_diff[XLEN:0] : rem_shift[XLEN:0];
                quot <= {quot[XLEN-2:0], rem_fits};
            end
        end else if (state == ST_FIX) begin
            result <= result_next;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops against
// an arithmetic reference model, busy/ignore, back-to-back and mid-op reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RV32M semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      pa;
        longint      pb;
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            3'd1: begin pa = longint'($signed(a)); pb = longint'($signed(b)); p = pa * pb; r = p[63:32]; end
            3'd2: begin pa = longint'($signed(a)); pb = longint'({32'b0, b}); p = pa * pb; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges from accept to done.
    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] mag;
        int          nbits;
        if (f3[2]) return (b == 0) ? 2 : 33;
        mag = ((f3 == 3'd1) && b[31]) ? (~b + 32'd1) : b;
        nbits = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) nbits = i + 1;
        return ((nbits < 1) ? 1 : nbits) + 1;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait for done, report what was seen.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output logic busy_acc, output logic done_after,
                          output logic busy_after);
        @(negedge clk);
        funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_acc = busy;
        rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom); funct3 = 3'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 60);
        res = result;
        rdo = rd_out;
        @(posedge clk); #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        checks++; if (rd_out !== 5'h0)  begin errors++; $display("FAIL reset_rd_out: got %h expected 0", rd_out); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  f3v [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6, 3'd6};
        logic [31:0] av  [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] bv  [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                                  32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] ev  [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'd14, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFF9};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        logic        b_acc, d_aft, b_aft;
        for (int i = 0; i < 12; i++) begin
            run_op(f3v[i], av[i], bv[i], 5'(i + 1), res, rdo, lat, b_acc, d_aft, b_aft);
            checks++; if (res !== ev[i]) begin errors++; $display("FAIL dir_result[%0d]: got %h expected %h", i, res, ev[i]); end
            checks++; if (rdo !== 5'(i + 1)) begin errors++; $display("FAIL dir_rd_out[%0d]: got %0d expected %0d", i, rdo, i + 1); end
            checks++; if (lat !== exp_latency(f3v[i], bv[i])) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(f3v[i], bv[i])); end
            checks++; if (b_acc !== 1'b1) begin errors++; $display("FAIL dir_busy_accept[%0d]: got %b expected 1", i, b_acc); end
            checks++; if (d_aft !== 1'b0 || b_aft !== 1'b0) begin errors++; $display("FAIL dir_after_done[%0d]: done %b busy %b expected 0 0", i, d_aft, b_aft); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, expv;
        logic [4:0]  rd, rdo;
        int          lat;
        logic        b_acc, d_aft, b_aft;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            rd = 5'($urandom);
            expv = model(f3, a, b);
            run_op(f3, a, b, rd, res, rdo, lat, b_acc, d_aft, b_aft);
            checks++; if (res !== expv) begin errors++; $display("FAIL rand_result[%0d] f3=%0d a=%h b=%h: got %h expected %h", i, f3, a, b, res, expv); end
            checks++; if (rdo !== rd) begin errors++; $display("FAIL rand_rd_out[%0d]: got %0d expected %0d", i, rdo, rd); end
            checks++; if (lat !== exp_latency(f3, b)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(f3, b)); end
            checks++; if (d_aft !== 1'b0 || b_aft !== 1'b0) begin errors++; $display("FAIL rand_after_done[%0d]: done %b busy %b expected 0 0", i, d_aft, b_aft); end
        end
    endtask

    task automatic test_busy_ignore();
        int          pulses = 0;
        int          done_c = -1;
        logic        busy_late = 1'b0;
        logic [31:0] res = '0;
        logic [4:0]  rdo = '0;
        @(negedge clk);
        funct3 = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_c >= 0 && busy) busy_late = 1'b1;
            if (c == 4) begin
                start = 1'b1; funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_addr = 5'd17;
            end
            if (done) begin
                pulses++;
                res = result;
                rdo = rd_out;
                done_c = c;
                start = 1'b1;
            end
        end
        start = 1'b0;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
        checks++; if (res !== 32'd333) begin errors++; $display("FAIL ignore_result: got %h expected %h", res, 32'd333); end
        checks++; if (rdo !== 5'd3) begin errors++; $display("FAIL ignore_rd_out: got %0d expected 3", rdo); end
        checks++; if (busy_late !== 1'b0) begin errors++; $display("FAIL ignore_start_in_done: busy after done %b expected 0", busy_late); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int g = 0;
        @(negedge clk);
        funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr = 5'd9; start = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!done && n < 80);
        checks++; if (n !== 34) begin errors++; $display("FAIL b2b_first: got %0d edges expected 34", n); end
        do begin @(posedge clk); #1; g++; end while (!done && g < 80);
        checks++; if (g !== 35) begin errors++; $display("FAIL b2b_gap: got %0d edges expected 35", g); end
        checks++; if (result !== 32'd14 || rd_out !== 5'd9) begin errors++; $display("FAIL b2b_result: got %h/%0d expected %h/9", result, rd_out, 32'd14); end
        @(negedge clk); start = 1'b0;
        n = 0;
        while (busy && n < 80) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset_mid();
        int          pulses = 0;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        logic        b_acc, d_aft, b_aft;
        @(negedge clk);
        funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd5; rd_addr = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_status: busy %b done %b expected 0 0", busy, done); end
        checks++; if (result !== 32'h0 || rd_out !== 5'h0) begin errors++; $display("FAIL midrst_outputs: result %h rd_out %0d expected 0 0", result, rd_out); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
        run_op(3'd3, 32'hDEADBEEF, 32'h12345678, 5'd21, res, rdo, lat, b_acc, d_aft, b_aft);
        checks++; if (res !== model(3'd3, 32'hDEADBEEF, 32'h12345678)) begin errors++; $display("FAIL midrst_next_result: got %h expected %h", res, model(3'd3, 32'hDEADBEEF, 32'h12345678)); end
        checks++; if (lat !== exp_latency(3'd3, 32'h12345678) || rdo !== 5'd21) begin errors++; $display("FAIL midrst_next_op: lat %0d rd %0d expected %0d 21", lat, rdo, exp_latency(3'd3, 32'h12345678)); end
    endtask

`ifdef MULDIV_EARLY_OUT_EN
    task automatic test_early_out();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        logic        b_acc, d_aft, b_aft;
        run_op(3'd0, 32'h12345, 32'h0, 5'd2, res, rdo, lat, b_acc, d_aft, b_aft);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL early_result: got %h expected 0", res); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL early_latency: got %0d expected 2", lat); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef MULDIV_EARLY_OUT_EN
        test_early_out();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
